// File: rtl/seg7_scan_hex.sv
// Time-multiplexed hex display driver: scans NDIG digits, DIV clocks per digit,
// with double-buffered data that only switches at frame boundaries.
module seg7_scan_hex #(
    parameter int NDIG       = 4,
    parameter int DIV        = 16,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit LZS        = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [4*NDIG-1:0] data,
    input  logic [NDIG-1:0]   blank,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   dig,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [6:0]       SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NDIG-1:0]  DIG_OFF  = ACTIVE_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4*NDIG-1:0] act_data_q, act_data_d;
    logic [NDIG-1:0]   act_blank_q, act_blank_d;
    logic [4*NDIG-1:0] pend_data_q, pend_data_d;
    logic [NDIG-1:0]   pend_blank_q, pend_blank_d;
    logic              pend_vld_q, pend_vld_d;
    logic [6:0]        seg_q, seg_d;
    logic [NDIG-1:0]   dig_q, dig_d;
    logic              frame_done_q;

    logic              cnt_wrap, idx_wrap, boundary;
    logic [NDIG-1:0]   lz_sup;
    logic              all_zero;
    logic [3:0]        cur_nib;
    logic              cur_blk;
    logic [6:0]        seg_log;
    logic [NDIG-1:0]   dig_log;

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        idx_wrap = (idx_q == IDX_LAST);
        boundary = cnt_wrap && idx_wrap;
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (cnt_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + 1'b1;
        end
    end

    // Transfer consumes the pending contents held before this edge; a
    // coincident load refills pending and keeps the flag set.
    always_comb begin
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_vld_d   = pend_vld_q;
        act_data_d   = act_data_q;
        act_blank_d  = act_blank_q;
        if (boundary && pend_vld_q) begin
            act_data_d  = pend_data_q;
            act_blank_d = pend_blank_q;
            pend_vld_d  = 1'b0;
        end
        if (load) begin
            pend_data_d  = data;
            pend_blank_d = blank;
            pend_vld_d   = 1'b1;
        end
    end

    // Leading-zero mask: digit k is suppressed when nibbles k..NDIG-1 are all zero.
    always_comb begin
        all_zero = 1'b1;
        lz_sup   = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            all_zero  = all_zero & (act_data_q[4*k +: 4] == 4'h0);
            lz_sup[k] = LZS && (k > 0) && all_zero;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_blk = 1'b0;
        dig_log = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib    = act_data_q[4*k +: 4];
                cur_blk    = act_blank_q[k] | lz_sup[k];
                dig_log[k] = 1'b1;
            end
        end
        seg_log = cur_blk ? 7'h00 : hex_to_seg(cur_nib);
        seg_d   = ACTIVE_LOW ? ~seg_log : seg_log;
        dig_d   = ACTIVE_LOW ? ~dig_log : dig_log;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_data_q   <= '0;
            act_blank_q  <= '0;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            pend_vld_q   <= 1'b0;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_blank_q  <= act_blank_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_vld_q   <= pend_vld_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= boundary;
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_hex.md
SEG7_SCAN_HEX -- requirements
Module: seg7_scan_hex

Interface
REQ-001 Parameter NDIG, default 4, number of multiplexed hex digits, legal range 1..8.
REQ-002 Parameter DIV, default 16, clock cycles each digit is displayed, legal range 2..65535.
REQ-003 Parameter ACTIVE_LOW, default 0, 1 inverts both seg and dig outputs.
REQ-004 Parameter LZS, default 0, 1 enables leading-zero suppression.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 load  in  1  capture data/blank into the pending buffer this cycle.
REQ-008 data  in  4*NDIG  hex nibbles; digit k is data[4k+3:4k], digit 0 is least significant.
REQ-009 blank  in  NDIG  per-digit forced blank, bit k blanks digit k.
REQ-010 seg  out  7  segment pattern {g,f,e,d,c,b,a}, registered.
REQ-011 dig  out  NDIG  one-hot digit enable, registered.
REQ-012 frame_done  out  1  one-cycle pulse at each frame wrap.

Function
REQ-013 Logical segment codes (1 = lit) SHALL be, for nibbles 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71 (hex, bit0 = a).
REQ-014 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; each wrap SHALL advance digit index idx by 1, wrapping from NDIG-1 to 0.
REQ-015 On a cycle where cnt wraps and idx wraps (frame boundary), frame_done SHALL be 1 for exactly one cycle; otherwise 0.
REQ-016 load=1 SHALL write data and blank into the pending buffer and set the pending flag; a later load before transfer overwrites it (last load wins).
REQ-017 At a frame boundary with the pending flag set, the pending buffer SHALL be copied to the active buffer and the flag cleared; mid-frame, the active buffer SHALL NOT change.
REQ-018 A load coinciding with a frame boundary SHALL land in pending only; the transfer uses the pending contents held before that edge, and the new value is shown from the next frame on.
REQ-019 Digit k SHALL be blanked (seg logical 0x00) when its active blank bit is set, or when LZS=1, k>0 and all active nibbles k..NDIG-1 are zero.
REQ-020 seg and dig SHALL be registered from the current idx and active buffer, so they lag idx by one clock.
REQ-021 dig logical value SHALL be one-hot at bit idx; NDIG=1 gives dig constantly 1 after the first post-reset cycle.
REQ-022 With ACTIVE_LOW=1, seg and dig SHALL be the bitwise inverse of their logical values, with blanking applied before inversion.

Reset
REQ-023 rst=1 SHALL clear cnt, idx, the active buffer, the pending buffer, the pending flag and frame_done.
REQ-024 During reset and on the first cycle after it, seg and dig SHALL be logically all-off: 0 for ACTIVE_LOW=0, all-ones for ACTIVE_LOW=1.
REQ-025 rst SHALL take priority over load; reset mid-frame SHALL discard any pending data.

Verification
REQ-026 NDIG=4, DIV=4, load data=16'h12AF, blank=0 -> after the next frame boundary, successive digit slots (4 cycles each) show seg 71, 77, 5B, 06 with dig 0001, 0010, 0100, 1000, and frame_done pulses every 16 cycles.
REQ-027 Loads of 16'h1111 then 16'h2222 within one frame -> only 2222 is displayed next frame; 1111 never appears.
REQ-028 Load 16'h0000 asserted on a frame-boundary cycle, while displaying 16'hFFFF -> the next full frame still shows FFFF, the frame after shows 0000.
REQ-029 LZS=1, data=16'h0070 -> digits 3 and 2 show 00, digit 1 shows 07, digit 0 shows 3F; blank=4'b0010 additionally blanks digit 1.
REQ-030 ACTIVE_LOW=1, rst held 3 cycles mid-frame with a pending load -> seg=7F and dig=F during reset; after release all digits show 0 (seg=40), and the pending data is never shown.
